// File: rtl/sine_nco.sv
// Numerically controlled sine source that feeds a DAC one offset-binary sample every DIV clocks.
// Frequency words are accepted at any time but only take effect on a sample boundary.
module sine_nco #(
    parameter int          DIV     = 4,
    parameter logic [15:0] FTW_RST = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] ftw,
    input  logic        ftw_valid,
    output logic        ftw_ready,
    output logic [7:0]  O_data,
    output logic        en,
    output logic        busy
);

    localparam int CW = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t        state_q, state_d;
    logic [15:0]   phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cy_q, cy_d;
    logic [15:0]   ftw_act_q, ftw_act_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [7:0]    odata_q, odata_d;
    logic          en_q, en_d;
    logic [15:0]   step;
    logic [16:0]   sum;

    // First quadrant of the wave: round(127*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [6:0] quarter(input logic [6:0] k);
        logic [6:0] q;
        q = 7'd0;
        case (k)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Odd quadrants read the table mirrored, the upper half is negated about 128
    function automatic logic [7:0] sine_f(input logic [7:0] p);
        logic [6:0] idx;
        logic [7:0] q;
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        q   = {1'b0, quarter(idx)};
        return p[7] ? (8'd128 - q) : (8'd128 + q);
    endfunction

    assign ftw_ready = (state_q == IDLE) || !pend_valid_q;
    assign busy      = (state_q != IDLE);
    assign O_data    = odata_q;
    assign en        = en_q;
    // A pending word becomes the step used on the very boundary that adopts it
    assign step      = pend_valid_q ? pend_q : ftw_act_q;
    assign sum       = {1'b0, phase_q} + {1'b0, step};

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        cy_d         = cy_q;
        ftw_act_d    = ftw_act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        odata_d      = odata_q;
        en_d         = 1'b0;

        if (state_q == IDLE) begin
            if (ftw_valid) ftw_act_d = ftw;
            if (start) begin
                state_d = RUN;
                phase_d = 16'h0000;
                cnt_d   = '0;
                cy_d    = 1'b0;
            end
        end else begin
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
            if (ftw_valid && ftw_ready) begin
                pend_d       = ftw;
                pend_valid_d = 1'b1;
            end
            if (state_q == RUN && stop) state_d = STOPPING;
            if (cnt_q == '0) begin
                en_d      = 1'b1;
                ftw_act_d = step;
                if (pend_valid_q) pend_valid_d = 1'b0;
                // Stop lands on a wrap (or a frozen step) so the wave ends at mid-scale
                if (state_q == STOPPING && (cy_q || ftw_act_q == 16'h0000)) begin
                    odata_d = 8'h80;
                    phase_d = 16'h0000;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    odata_d = sine_f(phase_q[15:8]);
                    phase_d = sum[15:0];
                    cy_d    = sum[16];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= 16'h0000;
            cnt_q        <= '0;
            cy_q         <= 1'b0;
            ftw_act_q    <= FTW_RST;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
            odata_q      <= 8'h80;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            cy_q         <= cy_d;
            ftw_act_q    <= ftw_act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            odata_q      <= odata_d;
            en_q         <= en_d;
        end
    end

endmodule

// File: tb/tb_sine_nco.sv
// Directed bench for sine_nco: table of sample values per tuning word, plus hand sequences
// for tuning-word hand-off, stopping and mid-run reset.
module tb_sine_nco;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] ftw;
    logic        ftw_valid;
    logic        ftw_ready;
    logic [7:0]  O_data;
    logic        en;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] strobes [0:255];

    typedef struct {
        logic [15:0] word;
        int          idx;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [0:17];

    sine_nco #(.DIV(DIV), .FTW_RST(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .ftw(ftw), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
        .O_data(O_data), .en(en), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ftw_valid = 1'b0; ftw = 16'h0000;
        step_clk();
        step_clk();
        rst_n = 1'b1;
    endtask

    task automatic load_and_start(input logic [15:0] w);
        ftw = w; ftw_valid = 1'b1;
        step_clk();
        ftw_valid = 1'b0; start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    task automatic expect_strobe(input string name, input logic [7:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * DIV && !seen; i++) begin
            step_clk();
            if (en) seen = 1'b1;
        end
        if (!seen) check_output({name, "_timeout"}, 16'h0000, 16'h0001);
        else       check_output(name, {8'h00, O_data}, {8'h00, exp});
    endtask

    // Runs one tuning word from reset, recording every sample and its arrival cycle
    task automatic apply_stimulus(input logic [15:0] w, input int n);
        int cyc = 1;
        int got = 0;
        do_reset();
        load_and_start(w);
        while (got < n && cyc < n * DIV + 50) begin
            step_clk();
            cyc++;
            if (en) begin
                strobes[got] = O_data;
                check_output("strobe_time", 16'(cyc), 16'(2 + got * DIV));
                got++;
            end
        end
        if (got < n) check_output("strobe_count", 16'(got), 16'(n));
    endtask

    initial begin
        logic [15:0] cur;
        int          en_cnt;

        vecs[0]  = '{16'h0100, 1,   8'h80};
        vecs[1]  = '{16'h0100, 17,  8'hB1};
        vecs[2]  = '{16'h0100, 33,  8'hDA};
        vecs[3]  = '{16'h0100, 44,  8'hEF};
        vecs[4]  = '{16'h0100, 65,  8'hFF};
        vecs[5]  = '{16'h0100, 81,  8'hF5};
        vecs[6]  = '{16'h0100, 129, 8'h80};
        vecs[7]  = '{16'h0100, 145, 8'h4F};
        vecs[8]  = '{16'h0100, 193, 8'h01};
        vecs[9]  = '{16'h0100, 209, 8'h0B};
        vecs[10] = '{16'h4000, 1,   8'h80};
        vecs[11] = '{16'h4000, 2,   8'hFF};
        vecs[12] = '{16'h4000, 3,   8'h80};
        vecs[13] = '{16'h4000, 4,   8'h01};
        vecs[14] = '{16'h4000, 6,   8'hFF};
        vecs[15] = '{16'h0800, 2,   8'h99};
        vecs[16] = '{16'h0800, 9,   8'hFF};
        vecs[17] = '{16'h0800, 11,  8'hF5};

        do_reset();
        check_output("rst_odata", {8'h00, O_data}, 16'h0080);
        check_output("rst_en", {15'h0, en}, 16'h0000);
        check_output("rst_busy", {15'h0, busy}, 16'h0000);
        check_output("rst_ready", {15'h0, ftw_ready}, 16'h0001);

        cur = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].word != cur) begin
                apply_stimulus(vecs[i].word, (vecs[i].word == 16'h0100) ? 210 : 12);
                cur = vecs[i].word;
            end
            check_output($sformatf("vec%0d", i), {8'h00, strobes[vecs[i].idx - 1]}, {8'h00, vecs[i].exp});
        end

        // New word offered mid-interval waits for the next boundary
        do_reset();
        start = 1'b1; step_clk(); start = 1'b0;
        expect_strobe("hand_s1", 8'h80);
        ftw = 16'h4000; ftw_valid = 1'b1;
        step_clk();
        ftw_valid = 1'b0;
        check_output("hand_ready_low", {15'h0, ftw_ready}, 16'h0000);
        while (!en) begin
            if (ftw_ready) begin
                check_output("hand_ready_held", 16'h0001, 16'h0000);
                break;
            end
            step_clk();
        end
        if (en) check_output("hand_s2", {8'h00, O_data}, 16'h0083);
        check_output("hand_ready_back", {15'h0, ftw_ready}, 16'h0001);
        expect_strobe("hand_s3", 8'hFF);
        expect_strobe("hand_s4", 8'h7D);

        // Stop after the peak: wave runs on until the phase wraps, ending at mid-scale
        do_reset();
        load_and_start(16'h4000);
        expect_strobe("stop_s1", 8'h80);
        expect_strobe("stop_s2", 8'hFF);
        stop = 1'b1; step_clk(); stop = 1'b0;
        check_output("stop_busy", {15'h0, busy}, 16'h0001);
        expect_strobe("stop_s3", 8'h80);
        expect_strobe("stop_s4", 8'h01);
        expect_strobe("stop_s5", 8'h80);
        check_output("stop_idle", {15'h0, busy}, 16'h0000);
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            if (en) en_cnt++;
        end
        check_output("stop_no_en", 16'(en_cnt), 16'h0000);

        // Reset mid-run with a word pending: pending word is lost, default step returns
        do_reset();
        load_and_start(16'h0800);
        expect_strobe("mrst_s1", 8'h80);
        ftw = 16'h4000; ftw_valid = 1'b1; step_clk(); ftw_valid = 1'b0;
        check_output("mrst_pending", {15'h0, ftw_ready}, 16'h0000);
        rst_n = 1'b0; step_clk();
        check_output("mrst_odata", {8'h00, O_data}, 16'h0080);
        check_output("mrst_en", {15'h0, en}, 16'h0000);
        check_output("mrst_busy", {15'h0, busy}, 16'h0000);
        check_output("mrst_ready", {15'h0, ftw_ready}, 16'h0001);
        rst_n = 1'b1;
        start = 1'b1; step_clk(); start = 1'b0;
        expect_strobe("mrst_s1b", 8'h80);
        expect_strobe("mrst_s2b", 8'h83);
        expect_strobe("mrst_s3b", 8'h86);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
